// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue stage: op codes, FSM encoding, result FIFO sizing.
package alu_issue_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 4'd4;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = 2;
    localparam int unsigned FIFO_CNT_W = 3;
    localparam int unsigned INFL_W     = 2;

endpackage

// File: rtl/alu_issue_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the priority pointer.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o_c
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin : arb
        int unsigned idx;
        logic        found;
        gnt_o_c = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (en_i && !found && req_i[PW'(idx)]) begin
                found            = 1'b1;
                gnt_o_c[PW'(idx)] = 1'b1;
                ptr_d            = PW'((idx + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: arbitrates requesters onto the ALU, tracks credits, and buffers
// results in a small FIFO for the writeback handshake, with a drain-style flush.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RSBIT = 3,
    parameter int unsigned NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*RSBIT-1:0] req_rs,
    input  logic [NREQ*OP_W-1:0]  req_op,
    input  logic [NREQ*WIDTH-1:0] req_vl,
    input  logic [NREQ*WIDTH-1:0] req_vr,
    output logic [RSBIT-1:0]      alu_rs_i,
    output logic [OP_W-1:0]       alu_op,
    output logic [WIDTH-1:0]      alu_vl,
    output logic [WIDTH-1:0]      alu_vr,
    input  logic [RSBIT-1:0]      alu_rs,
    input  logic [WIDTH-1:0]      alu_result,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [RSBIT-1:0]      wb_rs,
    output logic [WIDTH-1:0]      wb_result,
    input  logic                  flush
);

    logic [0:0]            state_q, state_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [INFL_W-1:0]     inflight_q, inflight_d;
    logic [RSBIT-1:0]      fifo_rs_q  [FIFO_DEPTH];
    logic [RSBIT-1:0]      fifo_rs_d  [FIFO_DEPTH];
    logic [WIDTH-1:0]      fifo_res_q [FIFO_DEPTH];
    logic [WIDTH-1:0]      fifo_res_d [FIFO_DEPTH];

    logic [RSBIT-1:0] iss_rs_q, iss_rs_d;
    logic [OP_W-1:0]  iss_op_q, iss_op_d;
    logic [WIDTH-1:0] iss_vl_q, iss_vl_d;
    logic [WIDTH-1:0] iss_vr_q, iss_vr_d;

    logic             wb_valid_q, wb_valid_d;
    logic [RSBIT-1:0] wb_rs_q, wb_rs_d;
    logic [WIDTH-1:0] wb_res_q, wb_res_d;

    logic [NREQ-1:0]  gnt_c;
    logic             grant_en_c;
    logic             pop_c;
    logic             push_c;
    logic             alu_ret_c;
    logic             issue_c;
    logic [3:0]       occ_c;
    logic [RSBIT-1:0] sel_rs_c;
    logic [OP_W-1:0]  sel_op_c;
    logic [WIDTH-1:0] sel_vl_c;
    logic [WIDTH-1:0] sel_vr_c;

    // A same-cycle pop frees its entry before the credit test; reset blocks all grants.
    always_comb begin
        pop_c      = wb_valid_q & wb_ready;
        alu_ret_c  = (alu_rs != '0);
        occ_c      = 4'(count_q) + 4'(inflight_q) - 4'(pop_c);
        grant_en_c = rst && (state_q == ST_RUN) && !flush && (occ_c < 4'(FIFO_DEPTH));
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst),
        .en_i    (grant_en_c),
        .req_i   (req_valid),
        .gnt_o_c (gnt_c)
    );

    assign req_ready = gnt_c;

    always_comb begin
        sel_rs_c = '0;
        sel_op_c = '0;
        sel_vl_c = '0;
        sel_vr_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                sel_rs_c = req_rs[i*RSBIT +: RSBIT];
                sel_op_c = req_op[i*OP_W +: OP_W];
                sel_vl_c = req_vl[i*WIDTH +: WIDTH];
                sel_vr_c = req_vr[i*WIDTH +: WIDTH];
            end
        end
        issue_c = (|gnt_c) && (sel_rs_c != '0);
    end

    // Tag-0 grants are consumed here: no ALU issue, operand registers hold.
    always_comb begin
        iss_rs_d = issue_c ? sel_rs_c : '0;
        iss_op_d = issue_c ? sel_op_c : iss_op_q;
        iss_vl_d = issue_c ? sel_vl_c : iss_vl_q;
        iss_vr_d = issue_c ? sel_vr_c : iss_vr_q;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        push_c     = 1'b0;
        inflight_d = inflight_q + INFL_W'(issue_c) - INFL_W'(alu_ret_c);
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            fifo_rs_d[j]  = fifo_rs_q[j];
            fifo_res_d[j] = fifo_res_q[j];
        end
        case (state_q)
            ST_RUN: begin
                push_c = alu_ret_c;
                if (push_c) begin
                    fifo_rs_d[wr_ptr_q]  = alu_rs;
                    fifo_res_d[wr_ptr_q] = alu_result;
                    wr_ptr_d             = wr_ptr_q + FIFO_PTR_W'(1);
                end
                if (pop_c) begin
                    rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
                end
                count_d = count_q + FIFO_CNT_W'(push_c) - FIFO_CNT_W'(pop_c);
                if (flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Results returning while in flight are dropped; clear once the ALU is empty.
                if (inflight_q == '0) begin
                    state_d  = ST_RUN;
                    count_d  = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        wb_valid_d = (state_d == ST_RUN) && (count_d != '0);
        wb_rs_d    = fifo_rs_d[rd_ptr_d];
        wb_res_d   = fifo_res_d[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                fifo_rs_q[j]  <= '0;
                fifo_res_q[j] <= '0;
            end
            iss_rs_q   <= '0;
            iss_op_q   <= '0;
            iss_vl_q   <= '0;
            iss_vr_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_rs_q    <= '0;
            wb_res_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                fifo_rs_q[j]  <= fifo_rs_d[j];
                fifo_res_q[j] <= fifo_res_d[j];
            end
            iss_rs_q   <= iss_rs_d;
            iss_op_q   <= iss_op_d;
            iss_vl_q   <= iss_vl_d;
            iss_vr_q   <= iss_vr_d;
            wb_valid_q <= wb_valid_d;
            wb_rs_q    <= wb_rs_d;
            wb_res_q   <= wb_res_d;
        end
    end

    assign alu_rs_i  = iss_rs_q;
    assign alu_op    = iss_op_q;
    assign alu_vl    = iss_vl_q;
    assign alu_vr    = iss_vr_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rs     = wb_rs_q;
    assign wb_result = wb_res_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a one-cycle ALU model feeds results back, and every
// accepted request queues its expected writeback, compared when the DUT presents it.
`timescale 1ns/1ps
module tb_alu_issue;
    import alu_issue_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned RSBIT = 3;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned SBW   = RSBIT + WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*RSBIT-1:0] req_rs;
    logic [NREQ*4-1:0]     req_op;
    logic [NREQ*WIDTH-1:0] req_vl;
    logic [NREQ*WIDTH-1:0] req_vr;
    logic [RSBIT-1:0]      alu_rs_i;
    logic [3:0]            alu_op;
    logic [WIDTH-1:0]      alu_vl;
    logic [WIDTH-1:0]      alu_vr;
    logic [RSBIT-1:0]      alu_rs;
    logic [WIDTH-1:0]      alu_result;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [RSBIT-1:0]      wb_rs;
    logic [WIDTH-1:0]      wb_result;
    logic                  flush;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rr_ptr = 0;
    bit chk_rr = 1'b0;
    logic [SBW-1:0] sb_q [$];
    logic [3:0] tops [5] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, 4'hB};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue #(.WIDTH(WIDTH), .RSBIT(RSBIT), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs     (req_rs),
        .req_op     (req_op),
        .req_vl     (req_vl),
        .req_vr     (req_vr),
        .alu_rs_i   (alu_rs_i),
        .alu_op     (alu_op),
        .alu_vl     (alu_vl),
        .alu_vr     (alu_vr),
        .alu_rs     (alu_rs),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rs      (wb_rs),
        .wb_result  (wb_result),
        .flush      (flush)
    );

    function automatic logic [WIDTH-1:0] alu_ref(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return '0;
        endcase
    endfunction

    // ALU with one registered stage
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_rs     <= '0;
            alu_result <= '0;
        end else begin
            alu_rs     <= alu_rs_i;
            alu_result <= alu_ref(alu_op, alu_vl, alu_vr);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [SBW-1:0]  head;
        logic [NREQ-1:0] exp_gnt;
        if (!rst) begin
            sb_q.delete();
            rr_ptr = 0;
        end else begin
            if (wb_valid) begin
                check("wb_expected", 64'(sb_q.size() != 0), 64'(1));
                if (sb_q.size() != 0) begin
                    head = sb_q[0];
                    check("wb_rs", 64'(wb_rs), 64'(head[SBW-1:WIDTH]));
                    check("wb_result", 64'(wb_result), 64'(head[WIDTH-1:0]));
                    if (wb_ready) void'(sb_q.pop_front());
                end
            end
            if (chk_rr) begin
                exp_gnt = NREQ'(1) << rr_ptr;
                check("rr_grant", 64'(req_ready), 64'(exp_gnt));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    rr_ptr = (i + 1) % int'(NREQ);
                    if (req_rs[i*RSBIT +: RSBIT] != '0)
                        sb_q.push_back({req_rs[i*RSBIT +: RSBIT],
                                        alu_ref(req_op[i*4 +: 4], req_vl[i*WIDTH +: WIDTH],
                                                req_vr[i*WIDTH +: WIDTH])});
                end
            end
            if (flush) sb_q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [RSBIT-1:0] rs, input logic [3:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_valid[i]              = 1'b1;
        req_rs[i*RSBIT +: RSBIT]  = rs;
        req_op[i*4 +: 4]          = op;
        req_vl[i*WIDTH +: WIDTH]  = a;
        req_vr[i*WIDTH +: WIDTH]  = b;
    endtask

    task automatic send(input int i, input logic [RSBIT-1:0] rs, input logic [3:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int hs);
        bit got = 1'b0;
        hs = -1;
        set_req(i, rs, op, a, b);
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1'b1;
                hs  = cyc;
            end
            step();
        end
        req_valid[i] = 1'b0;
        check("send_hs", 64'(got), 64'(1));
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0 && !wb_valid) done = 1'b1;
        end
        check("idle", 64'(done), 64'(1));
        step();
    endtask

    task automatic fill(input int want, output int n);
        n = 0;
        for (int k = 0; k < 20 && n < want; k++) begin
            @(negedge clk);
            n += $countones(req_valid & req_ready);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, lat, n;
        bit seen;
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
        req_valid = '1; req_rs = '0; req_op = '0; req_vl = '0; req_vr = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_alu_rs_i", 64'(alu_rs_i), 64'(0));
        check("rst_wb_valid", 64'(wb_valid), 64'(0));
        check("rst_wb_result", 64'(wb_result), 64'(0));
        step();
        rst = 1'b1; req_valid = '0; wb_ready = 1'b1;

        // Single ADD: latency and result
        step();
        send(0, 3'd3, ALU_ADD, 32'd5, 32'd7, hs);
        @(negedge clk);
        check("alu_rs_i_n1", 64'(alu_rs_i), 64'(3));
        check("alu_vl_n1", 64'(alu_vl), 64'(5));
        check("alu_vr_n1", 64'(alu_vr), 64'(7));
        lat = -1;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (wb_valid) lat = cyc - hs;
        end
        check("wb_latency", 64'(lat), 64'(3));
        check("wb_rs_3", 64'(wb_rs), 64'(3));
        check("wb_result_12", 64'(wb_result), 64'(12));
        wait_idle();

        // Remaining ops plus an undefined code
        for (int i = 0; i < 5; i++)
            send(i % int'(NREQ), RSBIT'(i + 1), tops[i], 32'(100 * (i + 3)), 32'(37 * i + 11), hs);
        wait_idle();

        // All requesters continuously valid: strict rotation, one grant per cycle
        for (int i = 0; i < NREQ; i++)
            set_req(i, RSBIT'(i + 1), (i % 2 == 0) ? ALU_ADD : ALU_XOR, 32'(i * 1000 + 1), 32'(i + 40));
        chk_rr = 1'b1;
        repeat (12) step();
        chk_rr = 1'b0; req_valid = '0;
        wait_idle();

        // Writeback stall: four results queue, then grants stop
        wb_ready = 1'b0;
        for (int i = 0; i < NREQ; i++)
            set_req(i, RSBIT'((i + 4) % 8 == 0 ? 1 : (i + 4) % 8), ALU_SUB, 32'(500 + i), 32'(i * 3));
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += $countones(req_valid & req_ready);
            step();
        end
        check("stall_grants", 64'(n), 64'(4));
        @(negedge clk);
        check("stall_ready_0", 64'(req_ready), 64'(0));
        check("stall_wb_valid", 64'(wb_valid), 64'(1));
        step();
        wb_ready = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += $countones(req_valid & req_ready);
            step();
        end
        check("stall_resume", 64'(n > 0), 64'(1));
        req_valid = '0;
        wait_idle();

        // Tag-0 request is consumed without an issue or writeback
        set_req(2, 3'd0, ALU_ADD, 32'd1, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = req_ready[2];
            step();
        end
        req_valid[2] = 1'b0;
        check("tag0_ready", 64'(seen), 64'(1));
        repeat (5) begin
            @(negedge clk);
            check("tag0_alu_rs_i", 64'(alu_rs_i), 64'(0));
            check("tag0_wb_valid", 64'(wb_valid), 64'(0));
        end
        step();

        // Flush with two queued and two in flight
        wb_ready = 1'b0;
        for (int i = 0; i < NREQ; i++)
            set_req(i, RSBIT'(i + 1), ALU_OR, 32'(i << 4), 32'(i + 1));
        fill(4, n);
        check("flush_fill", 64'(n), 64'(4));
        req_valid = '0;
        set_req(1, 3'd6, ALU_SUB, 32'd900, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        check("flush_nogrant_c0", 64'(req_ready), 64'(0));
        step();
        flush = 1'b0; wb_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("flush_nogrant", 64'(req_ready), 64'(0));
            check("flush_wb_valid", 64'(wb_valid), 64'(0));
            step();
        end
        @(negedge clk);
        check("flush_resume", 64'(req_ready), 64'(4'b0010));
        step();
        req_valid = '0;
        wait_idle();

        // Reset with three results buffered
        wb_ready = 1'b0;
        set_req(0, 3'd5, ALU_SUB, 32'd50, 32'd8);
        fill(3, n);
        check("rst_fill", 64'(n), 64'(3));
        req_valid = '0;
        step();
        step();
        req_valid[0] = 1'b1;
        rst = 1'b0;
        #1;
        check("arst_req_ready", 64'(req_ready), 64'(0));
        check("arst_alu_rs_i", 64'(alu_rs_i), 64'(0));
        check("arst_alu_op", 64'(alu_op), 64'(0));
        check("arst_alu_vl", 64'(alu_vl), 64'(0));
        check("arst_alu_vr", 64'(alu_vr), 64'(0));
        check("arst_wb_valid", 64'(wb_valid), 64'(0));
        check("arst_wb_rs", 64'(wb_rs), 64'(0));
        check("arst_wb_result", 64'(wb_result), 64'(0));
        step();
        step();
        rst = 1'b1; req_valid = '0; wb_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_wb_valid", 64'(wb_valid), 64'(0));
        end
        step();
        send(3, 3'd7, ALU_XOR, 32'hA5A5_0000, 32'h00FF_00FF, hs);
        wait_idle();
        check("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
